// File: rtl/warp_barrier_unit_pkg.sv
// Shared GPU barrier types plus the slot state encoding and width helper
// used by the warp barrier unit.

`define GPU_BARRIER_RSP_BITS (1 + warp_barrier_unit_pkg::GpuNumWarps)

package warp_barrier_unit_pkg;

  // Never returns less than one so single-entry configurations keep a usable index bit.
  function automatic int unsigned up_clog2(input int unsigned n);
    int unsigned bits;
    bits = 1;
    while ((32'd1 << bits) < n) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

  localparam int unsigned GpuNumWarps    = 4;
  localparam int unsigned GpuNumBarriers = 4;
  localparam int unsigned GpuNwBits      = up_clog2(GpuNumWarps);
  localparam int unsigned GpuNbBits      = up_clog2(GpuNumBarriers);

  typedef struct packed {
    logic                 valid;
    logic [GpuNbBits-1:0] id;
    logic [GpuNwBits-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic                   valid;
    logic [GpuNumWarps-1:0] wmask;
  } gpu_barrier_rsp_t;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } slot_state_e;

endpackage

// File: rtl/warp_barrier_unit.sv
// Per-core barrier tracker: records warp arrivals per barrier slot, holds the
// arrivals stalled and releases them together when the last participant arrives.

module warp_barrier_unit
  import warp_barrier_unit_pkg::*;
#(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  localparam int unsigned NwBits      = up_clog2(NUM_WARPS),
  localparam int unsigned NbBits      = up_clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [NbBits-1:0]    req_id,
  input  logic [NwBits-1:0]    req_size_m1,
  input  logic [NwBits-1:0]    req_wid,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic                 dup_err
);

  slot_state_e          state_q [NUM_BARRIERS];
  slot_state_e          state_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];
  logic [NwBits-1:0]    count_q [NUM_BARRIERS];
  logic [NwBits-1:0]    count_d [NUM_BARRIERS];
  logic [NwBits-1:0]    size_q  [NUM_BARRIERS];
  logic [NwBits-1:0]    size_d  [NUM_BARRIERS];

  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_wmask_q, rel_wmask_d;
  logic                 dup_q, dup_d;

  logic                 id_ok;
  logic [NUM_WARPS-1:0] wbit;

  assign id_ok = (32'(req_id) < NUM_BARRIERS);
  assign wbit  = NUM_WARPS'(1) << req_wid;

  always_comb begin
    state_d     = state_q;
    wmask_d     = wmask_q;
    count_d     = count_q;
    size_d      = size_q;
    rel_valid_d = 1'b0;
    rel_wmask_d = '0;
    dup_d       = dup_q;

    if (req_valid) begin
      if (!id_ok) begin
        dup_d = 1'b1;
      end else begin
        unique case (state_q[req_id])
          StIdle: begin
            if (req_size_m1 == '0) begin
              // Single-participant barrier: release the requester without opening the slot.
              rel_valid_d = 1'b1;
              rel_wmask_d = wbit;
            end else begin
              state_d[req_id] = StWait;
              wmask_d[req_id] = wbit;
              count_d[req_id] = '0;
              size_d[req_id]  = req_size_m1;
            end
          end
          StWait: begin
            if ((wmask_q[req_id] & wbit) != '0) begin
              dup_d = 1'b1;
            end else if (count_q[req_id] + NwBits'(1) == size_q[req_id]) begin
              rel_valid_d     = 1'b1;
              rel_wmask_d     = wmask_q[req_id] | wbit;
              state_d[req_id] = StIdle;
              wmask_d[req_id] = '0;
              count_d[req_id] = '0;
              size_d[req_id]  = '0;
            end else begin
              wmask_d[req_id] = wmask_q[req_id] | wbit;
              count_d[req_id] = count_q[req_id] + NwBits'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= StIdle;
        wmask_q[b] <= '0;
        count_q[b] <= '0;
        size_q[b]  <= '0;
      end
      rel_valid_q <= 1'b0;
      rel_wmask_q <= '0;
      dup_q       <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= state_d[b];
        wmask_q[b] <= wmask_d[b];
        count_q[b] <= count_d[b];
        size_q[b]  <= size_d[b];
      end
      rel_valid_q <= rel_valid_d;
      rel_wmask_q <= rel_wmask_d;
      dup_q       <= dup_d;
    end
  end

  // Built from registered slot state only, so released warps drop out the same cycle they pulse.
  always_comb begin
    stall_mask = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (state_q[b] == StWait) begin
        stall_mask = stall_mask | wmask_q[b];
      end
    end
  end

  assign release_valid = rel_valid_q;
  assign release_wmask = rel_wmask_q;
  assign dup_err       = dup_q;

endmodule

// File: tb/tb_warp_barrier_unit.sv
// Randomized and directed bench for warp_barrier_unit with a behavioural barrier model.

module tb_warp_barrier_unit;

  localparam int NW = 4;
  localparam int NB = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [1:0]    req_id;
  logic [1:0]    req_size_m1;
  logic [1:0]    req_wid;
  logic [NW-1:0] stall_mask;
  logic          release_valid;
  logic [NW-1:0] release_wmask;
  logic          dup_err;

  warp_barrier_unit #(
    .NUM_WARPS   (NW),
    .NUM_BARRIERS(NB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_id       (req_id),
    .req_size_m1  (req_size_m1),
    .req_wid      (req_wid),
    .stall_mask   (stall_mask),
    .release_valid(release_valid),
    .release_wmask(release_wmask),
    .dup_err      (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: which warps wait at each barrier and how many must arrive in total.
  bit waiting [NB][NW];
  int arrived [NB];
  int needed  [NB];
  bit open_b  [NB];

  logic [NW-1:0] exp_stall;
  logic          exp_rv;
  logic [NW-1:0] exp_rm;
  logic          exp_dup;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      open_b[b]  = 1'b0;
      arrived[b] = 0;
      needed[b]  = 0;
      for (int w = 0; w < NW; w++) waiting[b][w] = 1'b0;
    end
    exp_stall = '0;
    exp_rv    = 1'b0;
    exp_rm    = '0;
    exp_dup   = 1'b0;
  endtask

  task automatic model_req(input bit v, input int id, input int size, input int wid);
    exp_rv = 1'b0;
    exp_rm = '0;
    if (v) begin
      if (id >= NB) begin
        exp_dup = 1'b1;
      end else if (!open_b[id]) begin
        if (size == 0) begin
          exp_rv      = 1'b1;
          exp_rm[wid] = 1'b1;
        end else begin
          open_b[id]       = 1'b1;
          needed[id]       = size + 1;
          arrived[id]      = 1;
          waiting[id][wid] = 1'b1;
        end
      end else if (waiting[id][wid]) begin
        exp_dup = 1'b1;
      end else if (arrived[id] + 1 == needed[id]) begin
        exp_rv = 1'b1;
        for (int w = 0; w < NW; w++) begin
          exp_rm[w]       = waiting[id][w];
          waiting[id][w]  = 1'b0;
        end
        exp_rm[wid] = 1'b1;
        open_b[id]  = 1'b0;
        arrived[id] = 0;
        needed[id]  = 0;
      end else begin
        waiting[id][wid] = 1'b1;
        arrived[id]++;
      end
    end
    exp_stall = '0;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        if (open_b[b] && waiting[b][w]) exp_stall[w] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_mask", 32'(stall_mask), 32'(exp_stall));
      check("release_valid", 32'(release_valid), 32'(exp_rv));
      check("release_wmask", 32'(release_wmask), 32'(exp_rm));
      check("dup_err", 32'(dup_err), 32'(exp_dup));
    end
  end

  task automatic step(input bit v, input int id, input int size, input int wid);
    req_valid   = v;
    req_id      = 2'(id);
    req_size_m1 = 2'(size);
    req_wid     = 2'(wid);
    @(posedge clk);
    model_req(v, id, size, wid);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_id      = '0;
    req_size_m1 = '0;
    req_wid     = '0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_stall", 32'(stall_mask), 32'h0);
    check("reset_rv", 32'(release_valid), 32'h0);
    check("reset_dup", 32'(dup_err), 32'h0);

    // Basic: three participants on barrier 1.
    step(1, 1, 2, 0);
    check("basic_stall0", 32'(stall_mask), 32'h1);
    step(1, 1, 2, 2);
    check("basic_stall1", 32'(stall_mask), 32'h5);
    step(1, 1, 2, 3);
    check("basic_rv", 32'(release_valid), 32'h1);
    check("basic_rm", 32'(release_wmask), 32'hd);
    check("basic_stall2", 32'(stall_mask), 32'h0);
    step(0, 0, 0, 0);
    check("pulse_one_cycle", 32'(release_valid), 32'h0);

    // Trivial single-participant barrier.
    step(1, 0, 0, 2);
    check("triv_rm", 32'(release_wmask), 32'h4);
    check("triv_stall", 32'(stall_mask), 32'h0);

    // Duplicate arrival.
    step(1, 2, 1, 1);
    check("dup_stall0", 32'(stall_mask), 32'h2);
    step(1, 2, 1, 1);
    check("dup_err", 32'(dup_err), 32'h1);
    check("dup_no_rel", 32'(release_valid), 32'h0);
    check("dup_stall1", 32'(stall_mask), 32'h2);
    step(1, 2, 1, 3);
    check("dup_rm", 32'(release_wmask), 32'ha);

    // Interleaved barriers 0 and 3.
    step(1, 0, 1, 0);
    step(1, 3, 1, 2);
    check("conc_stall", 32'(stall_mask), 32'h5);
    step(1, 0, 1, 1);
    check("conc_rm0", 32'(release_wmask), 32'h3);
    check("conc_stall1", 32'(stall_mask), 32'h4);
    step(1, 3, 1, 3);
    check("conc_rm1", 32'(release_wmask), 32'hc);

    // Slot reuse right after release.
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    check("reuse_rm", 32'(release_wmask), 32'h3);
    step(1, 0, 1, 2);
    check("reuse_stall", 32'(stall_mask), 32'h4);

    // Reset mid-wait.
    step(1, 2, 2, 0);
    step(1, 2, 2, 1);
    check("pre_reset_stall", 32'(stall_mask), 32'h7);
    do_reset();
    check("rst_stall", 32'(stall_mask), 32'h0);
    check("rst_rv", 32'(release_valid), 32'h0);
    check("rst_dup", 32'(dup_err), 32'h0);
    step(1, 2, 1, 3);
    check("fresh_stall", 32'(stall_mask), 32'h8);
    step(1, 2, 1, 0);
    check("fresh_rm", 32'(release_wmask), 32'h9);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, int'($urandom_range(0, NB - 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, NW - 1)));
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/warp_barrier_unit.md
# warp_barrier_unit

Per-core barrier tracker that sits directly downstream of the barrier decode in the warp-control path. It consumes barrier requests (valid, barrier id, participant count minus one) issued by a warp, records arrivals per barrier, and holds arriving warps stalled. When the last participant arrives it emits a one-cycle release of every waiting warp to the warp scheduler.

## Interface
Parameters:
- NUM_WARPS, 4: warps per core; NW_BITS = UP(CLOG2(NUM_WARPS)).
- NUM_BARRIERS, 4: barrier slots; NB_BITS = UP(CLOG2(NUM_BARRIERS)).

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high; clears all state.
- req_valid  in  1  one-cycle barrier request pulse; always accepted, no ready.
- req_id  in  NB_BITS  barrier slot index.
- req_size_m1  in  NW_BITS  participating warps minus one.
- req_wid  in  NW_BITS  arriving warp id.
- stall_mask  out  NUM_WARPS  warps currently held at any barrier; reset 0.
- release_valid  out  1  release pulse; reset 0.
- release_wmask  out  NUM_WARPS  warps released this cycle; reset 0; 0 when release_valid=0.
- dup_err  out  1  sticky: warp arrived twice at the same open barrier; reset 0.

## Operation
- Per slot state: wmask[NUM_WARPS], count[NW_BITS] (arrivals minus one), size_m1[NW_BITS], open flag. All zero after reset.
- Slot FSM: IDLE -> (first arrival, size_m1>0) -> WAIT -> (last arrival) -> IDLE. size_m1==0 releases requester immediately; slot stays IDLE.
- First arrival (slot IDLE): latch size_m1, wmask = 1<<wid, count = 0, go WAIT.
- Subsequent arrival (slot WAIT): size_m1 on request ignored; latched value governs. If wid bit already set in wmask: request dropped, dup_err set, no count change. Else if count+1 == size_m1: release (wmask | 1<<wid), clear slot to IDLE. Else set wid bit, count += 1.
- count never exceeds size_m1; no wrap possible under legal use. count arithmetic is NW_BITS wide, compared unsigned.
- stall_mask = OR of wmask over all WAIT slots (registered state, not request-combinational).
- A warp already stalled at slot A requesting slot B: accepted normally (scheduler must prevent this; unit does not check cross-slot).
- req_id >= NUM_BARRIERS: request dropped, dup_err set.
- reset mid-wait: all slots IDLE, no release pulse generated for discarded warps.

## Timing
- Request sampled at edge ending cycle N; release_valid/release_wmask asserted in cycle N+1 for exactly one cycle.
- stall_mask in N+1 reflects the request: set bit for a waiting arrival, cleared bits for released warps (released warps never appear stalled alongside release_valid).
- Throughput: one request per cycle, back-to-back to same or different slots; second request in N+1 sees slot state updated by request in N.
- Releasing slot is reusable by a request in the very next cycle (enters as first arrival).
- dup_err asserts in N+1 and holds until reset.

## Structure
- gpu_barrier_t (valid, id, size_m1) stays in the shared GPU types package; add gpu_barrier_rsp_t (valid, wmask) there for the release bundle, plus a GPU_BARRIER_RSP_BITS macro.
- Slot storage as flat register arrays indexed by req_id; no sub-module needed. Optional reuse of an existing one-hot-to-mask OR reduction utility for stall_mask.

## Test plan
- Basic: size_m1=2 on id 1, warps 0,2,3 arrive cycles 1,2,3 -> stall_mask 0001, 0101, then cycle 4 release_valid=1, release_wmask=1101, stall_mask=0000.
- Trivial: size_m1=0, wid 2 -> release_wmask=0100 next cycle, stall_mask never set.
- Duplicate: size_m1=1, warp 1 arrives twice -> dup_err=1, no release, stall_mask=0010; warp 3 then arrives -> release_wmask=1010.
- Concurrency: interleave ids 0 and 3 (size_m1=1 each, warps 0/1 and 2/3) on consecutive cycles -> two independent releases 0011 and 1100, stall_mask correct every cycle.
- Reuse: release on id 0 in cycle N, new first arrival to id 0 in N+1 -> slot reopens, stall_mask shows new warp in N+2.
- Reset mid-wait: two warps waiting on id 2, pulse reset -> stall_mask=0, release_valid=0, dup_err=0; subsequent barrier behaves as fresh.
